// File: rtl/pal_cfg_loader_pkg.sv
// Shared definitions for the PAL configuration loader: state codes and
// helpers that size the configuration stream from the PAL geometry.
package pal_cfg_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_FETCH = 3'd1;
    localparam state_t ST_SHIFT = 3'd2;
    localparam state_t ST_CHECK = 3'd3;
    localparam state_t ST_DONE  = 3'd4;
    localparam state_t ST_ERROR = 3'd5;

    // Configuration bits for a PAL with n inputs, m product terms and p outputs:
    // true+complement AND plane plus the OR plane.
    function automatic int default_cfg_bits(input int n, input int m, input int p);
        return 2 * n * m + m * p;
    endfunction

    // Payload bytes needed to carry a stream of the given bit length.
    function automatic int num_bytes(input int bits);
        return (bits + 7) / 8;
    endfunction

endpackage

// File: rtl/pal_cfg_loader_if.sv
// Byte-wide valid/ready feed carrying the PAL bitstream into the loader.
interface pal_cfg_loader_if;

    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;

    modport master (output din, output din_valid, input din_ready);
    modport slave  (input din, input din_valid, output din_ready);

endinterface

// File: rtl/pal_cfg_loader_shift_div.sv
// Shift-rate divider: while run is high it counts 0..SHIFT_DIV-1 and
// raises strobe in the last cycle of each period.
module pal_cfg_shift_div #(
    parameter int SHIFT_DIV = 4
) (
    input  logic clk,
    input  logic res,
    input  logic clr,
    input  logic run,
    output logic strobe
);

    localparam int DW = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(SHIFT_DIV - 1);

    logic [DW-1:0] div;

    assign strobe = run && (div == LAST);

    // Period counter; restarts on clear and after every strobe.
    always_ff @(posedge clk) begin
        if (res || clr) begin
            div <= '0;
        end else if (strobe) begin
            div <= '0;
        end else if (run) begin
            div <= div + 1'b1;
        end
    end

endmodule

// File: rtl/pal_cfg_loader.sv
// PAL configuration loader: takes bitstream bytes, shifts them LSB-first
// into the PAL, checks the XOR trailer and raises cfg_apply on a match.
module pal_cfg_loader
    import pal_cfg_pkg::*;
#(
    parameter int CFG_BITS  = default_cfg_bits(8, 26, 7),
    parameter int SHIFT_DIV = 4
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start,
    pal_cfg_loader_if.slave  bus,
    output logic             cfg_bit,
    output logic             cfg_shift,
    output logic             cfg_apply,
    output logic             busy,
    output logic             err
);

    localparam int CW = $clog2(CFG_BITS + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(CFG_BITS);

    state_t        state;
    logic [7:0]    shreg;
    logic [7:0]    checksum;
    logic [CW-1:0] bitcnt;
    logic [CW-1:0] bitcnt_next;
    logic [2:0]    byte_bit;
    logic          xfer;
    logic          launch;
    logic          shifting;
    logic          div_clr;
    logic          strobe;

    assign launch      = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));
    assign bus.din_ready = (state == ST_FETCH) || (state == ST_CHECK);
    assign xfer        = bus.din_valid && bus.din_ready;
    assign shifting    = (state == ST_SHIFT);
    assign div_clr     = launch || ((state == ST_FETCH) && xfer);
    assign bitcnt_next = bitcnt + 1'b1;

    assign cfg_bit   = shreg[0];
    assign cfg_shift = strobe;
    assign cfg_apply = (state == ST_DONE);
    assign err       = (state == ST_ERROR);
    assign busy      = (state == ST_FETCH) || (state == ST_SHIFT) || (state == ST_CHECK);

    pal_cfg_shift_div #(
        .SHIFT_DIV (SHIFT_DIV)
    ) u_div (
        .clk    (clk),
        .res    (res),
        .clr    (div_clr),
        .run    (shifting),
        .strobe (strobe)
    );

    // Load sequencer: fetch a byte, shift it out, repeat, then verify the trailer.
    always_ff @(posedge clk) begin
        if (res) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            checksum <= '0;
            bitcnt   <= '0;
            byte_bit <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state    <= ST_FETCH;
                        checksum <= '0;
                        bitcnt   <= '0;
                        byte_bit <= '0;
                    end
                end
                ST_FETCH: begin
                    if (xfer) begin
                        shreg    <= bus.din;
                        checksum <= checksum ^ bus.din;
                        byte_bit <= '0;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (strobe) begin
                        shreg    <= {1'b0, shreg[7:1]};
                        bitcnt   <= bitcnt_next;
                        byte_bit <= byte_bit + 3'd1;
                        if (bitcnt_next == LAST_BIT) begin
                            state <= ST_CHECK;
                        end else if (byte_bit == 3'd7) begin
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_CHECK: begin
                    if (xfer) begin
                        state <= (bus.din == checksum) ? ST_DONE : ST_ERROR;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/pal_cfg_loader.md
Name: pal_cfg_loader

Overview:
Upstream configuration feeder for the PAL fabric. It accepts the PAL bitstream as bytes over a valid/ready byte interface and serializes it LSB-first onto the PAL's single-bit configuration input at a programmable shift rate. It checks an XOR checksum trailer byte. Only on a match does it assert the apply/enable level that commits the configuration to the fabric.

Parameters:
CFG_BITS, 598, total configuration bits shifted into the PAL (default = 2*8*26 AND-plane + 26*7 OR-plane)
SHIFT_DIV, 4, clk cycles per shifted bit (>=1); cfg_shift strobes once per period
NUM_BYTES, ceil(CFG_BITS/8), derived; payload bytes expected before the checksum byte

Ports:
clk  in  1  single clock; all logic is rising-edge
res  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a new load (ignored while busy)
din  in  8  configuration byte
din_valid  in  1  din holds a valid byte
din_ready  out  1  loader accepts din this cycle (transfer = din_valid & din_ready)
cfg_bit  out  1  serial configuration data to PAL
cfg_shift  out  1  one-cycle strobe; PAL samples cfg_bit when high
cfg_apply  out  1  level; high after a verified load, drives PAL enable
busy  out  1  high in FETCH/SHIFT/CHECK
err  out  1  sticky checksum-mismatch flag, cleared by next start

Behaviour:
- Reset: state IDLE. din_ready, cfg_bit, cfg_shift, cfg_apply, busy and err are all 0. Shift register, checksum, bit counter and divider are 0. Reset mid-load aborts immediately; the partial PAL contents are left as-is with cfg_apply=0.
- States: IDLE, FETCH, SHIFT, CHECK, DONE, ERROR. busy=1 exactly in FETCH, SHIFT and CHECK.
- IDLE/DONE/ERROR + start:
  - clear err, cfg_apply, checksum, bit counter and divider
  - go to FETCH next cycle
  - start in any other state has no effect
- FETCH:
  - din_ready=1
  - on transfer: shreg<=din, checksum<=checksum^din, divider<=0, go to SHIFT
  - no timeout; FETCH waits indefinitely
- SHIFT:
  - din_ready=0; cfg_bit=shreg[0] (registered), stable for the whole period
  - divider counts 0..SHIFT_DIV-1; cfg_shift=1 only in the cycle the divider equals SHIFT_DIV-1
  - in that cycle: shreg>>=1, bitcnt++, divider<=0
  - if the new bitcnt==CFG_BITS, go to CHECK
  - else if 8 bits of the current byte are done, go to FETCH
- Partial last byte: only the low CFG_BITS mod 8 bits are shifted; the upper bits are ignored but still included in the checksum.
- CHECK:
  - din_ready=1
  - on transfer: if din==checksum go to DONE, else ERROR with err=1 next cycle
- DONE: cfg_apply=1, held until start or res.
- ERROR: cfg_apply=0, err=1, held until start or res.
- Latency:
  - first cfg_shift occurs SHIFT_DIV cycles after the accepting edge
  - each byte costs 8*SHIFT_DIV + 1 cycles (one FETCH cycle minimum; no prefetch)
  - cfg_apply rises 1 cycle after the checksum transfer
- Widths:
  - bitcnt is $clog2(CFG_BITS+1) bits; divider is $clog2(SHIFT_DIV) bits (min 1)
  - no wrap: bitcnt never exceeds CFG_BITS
- Simultaneous start and transfer in IDLE: the byte is not accepted (din_ready=0 in IDLE).

Decomposition:
- Package pal_cfg_pkg:
  - state enum (IDLE, FETCH, SHIFT, CHECK, DONE, ERROR)
  - function computing the default CFG_BITS from N/M/P
  - function for NUM_BYTES
- One sub-module: pal_cfg_shift_div. It is the divider/strobe generator with inputs clr and run, and output strobe. The FSM, shift register, counter and checksum stay in pal_cfg_loader.

Test Plan:
- CFG_BITS=12, SHIFT_DIV=2; start, then bytes 0xA5, 0x03, 0xA6:
  - cfg_bit sampled at the 12 cfg_shift strobes = 1,0,1,0,0,1,0,1,1,1,0,0
  - cfg_apply=1 one cycle after the 0xA6 transfer; err=0
- Same stream with checksum 0xA7:
  - same 12 strobes
  - err=1, cfg_apply=0, state ERROR; a following start clears err
- SHIFT_DIV=1, CFG_BITS=16; bytes 0xFF, 0x00, 0xFF:
  - cfg_shift high 8 consecutive cycles per byte
  - exactly 1 FETCH cycle gap between the two 8-strobe runs
- din_valid held low for 10 cycles mid-load:
  - din_ready stays 1, no cfg_shift strobes, bitcnt frozen
  - load resumes correctly when valid returns
- res asserted after 5 strobes:
  - next cycle all outputs 0 and state IDLE
  - a new start then shifts from bit 0
- start pulsed during SHIFT: ignored; the strobe count and the final cfg_apply match an undisturbed run.
